mult_seq_32bit: RTL

- Multi-cycle shift-and-add multiplier for the MIPS stub ALU.
- Sits directly downstream of add_32bit: instantiates one add_32bit as its only accumulation adder and consumes its Z/C_OUT every iteration.
- Produces the 64-bit HI/LO product for mult/multu.
- Trades 32+ cycles of latency for a single 32-bit ripple adder.

---
 rtl/mult_seq_32bit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mult_seq_32bit.sv
// Purpose : sequential shift-and-add 32x32->64 multiplier (mult/multu) built around one add_32bit.
// Latency : DONE in the cycle after edge k+32 (unsigned), k+33 (signed, MULT_SIGNED_EN builds).
// Backpressure: none; START is only sampled while BUSY=0, and requests made while BUSY=1 are dropped.
//
// Ports:
//   CLK, RST_N        rising-edge clock, asynchronous active-low reset
//   START, X, Y       request and operands, captured on the accepting edge
//   SIGNED            1 = mult, 0 = multu (only honoured when MULT_SIGNED_EN is defined)
//   BUSY, DONE        operation in progress / one-cycle product-valid pulse
//   Z_HI, Z_LO        product bits 63:32 / 31:0, held until the next accepted START
//
// Build option: define MULT_SIGNED_EN to enable signed multiplication (magnitude
// multiply followed by a one-cycle NEG state). Without it every operation is unsigned.

// 32-bit ripple-carry adder used as the multiplier's accumulation adder.
module add_32bit (
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        C_IN,
  output logic [31:0] Z,
  output logic        C_OUT
);

  logic carry;

  always_comb begin
    Z     = '0;
    carry = C_IN;
    for (int i = 0; i < 32; i++) begin
      Z[i]  = X[i] ^ Y[i] ^ carry;
      carry = (X[i] & Y[i]) | (X[i] & carry) | (Y[i] & carry);
    end
    C_OUT = carry;
  end

endmodule

module mult_seq_32bit (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic        SIGNED,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] Z_HI,
  output logic [31:0] Z_LO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] m_q,     m_d;      // multiplicand (magnitude for signed ops)
  logic [31:0] hi_q,    hi_d;     // upper product half / running accumulator
  logic [31:0] lo_q,    lo_d;     // multiplier bits shifting out, product bits shifting in
  logic [5:0]  cnt_q,   cnt_d;    // iteration counter, RUN exits after 32
  logic        sgn_q,   sgn_d;    // operation was signed: route through NEG
  logic        neg_q,   neg_d;    // product must be negated in NEG

  // ---------------------------------------------------------------------------
  // Operand conditioning
  // ---------------------------------------------------------------------------
  logic        op_signed;
  logic [31:0] op_x, op_y;
  logic        op_neg;

`ifdef MULT_SIGNED_EN
  assign op_signed = SIGNED;
`else
  // Unsigned-only build: SIGNED is referenced but forced to have no effect.
  assign op_signed = SIGNED & 1'b0;
`endif

  // Two's-complement magnitude; 0x80000000 negates to itself and is then
  // treated as the unsigned value 2^31, which is the correct magnitude.
  assign op_x   = (op_signed && X[31]) ? (~X + 32'd1) : X;
  assign op_y   = (op_signed && Y[31]) ? (~Y + 32'd1) : Y;
  assign op_neg = op_signed & (X[31] ^ Y[31]);

  // ---------------------------------------------------------------------------
  // Accumulation adder: adds the multiplicand into HI when the current
  // multiplier bit (LO[0]) is set. Its carry becomes the new HI MSB after the
  // right shift, so no 33rd accumulator bit is needed.
  // ---------------------------------------------------------------------------
  logic [31:0] add_y;
  logic [31:0] add_z;
  logic        add_co;

  assign add_y = lo_q[0] ? m_q : 32'd0;

  add_32bit u_add (
    .X     (hi_q),
    .Y     (add_y),
    .C_IN  (1'b0),
    .Z     (add_z),
    .C_OUT (add_co)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;

    unique case (state_q)
      IDLE, FIN: begin
        // FIN is the DONE cycle; a START here is accepted exactly as from IDLE.
        if (START) begin
          m_d     = op_x;
          hi_d    = 32'd0;
          lo_d    = op_y;
          cnt_d   = 6'd0;
          sgn_d   = op_signed;
          neg_d   = op_neg;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        {hi_d, lo_d} = {add_co, add_z, lo_q[31:1]};
        cnt_d        = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = sgn_q ? NEG : FIN;
        end
      end

      NEG: begin
        // Only reachable for signed operations; negation is a 64-bit two's complement.
        if (neg_q) begin
          {hi_d, lo_d} = ~{hi_q, lo_q} + 64'd1;
        end
        state_d = FIN;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: the product registers are the outputs, so the result holds until
  // the next accepted START overwrites HI/LO.
  // ---------------------------------------------------------------------------
  assign BUSY = (state_q == RUN) || (state_q == NEG);
  assign DONE = (state_q == FIN);
  assign Z_HI = hi_q;
  assign Z_LO = lo_q;

endmodule
